scr1_dmem_copy_engine: RTL and testbench
========================================

# scr1_dmem_copy_engine

Word-copy initiator on the SCR1 data-memory request/response interface. It is the master side of the protocol the TCM answers on its data port. Given a source address, destination address and word count, it issues alternating 32-bit reads and writes, one transaction outstanding at a time, until the count is exhausted or an error response arrives. It sits beside the core as a second dmem master, for TCM preload and scrub/copy jobs, behind the platform's dmem arbiter.

## Interface
Parameters:
- CNT_W, 16, width of word-count field; maximum job is 2^CNT_W-1 words

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  single-cycle job launch; sampled only in IDLE
- abort  in  1  stop request; honoured at next transaction boundary
- src_addr  in  `SCR1_DMEM_AWIDTH  first source byte address
- dst_addr  in  `SCR1_DMEM_AWIDTH  first destination byte address
- len  in  CNT_W  number of 32-bit words to copy
- busy  out  1  high from the cycle after an accepted start until the done pulse
- done  out  1  one-cycle pulse at job end (success, error or abort)
- err  out  1  sticky status of last job; cleared by next accepted start
- dmem_req  out  1  request valid
- dmem_req_ack  in  1  responder accepts request this cycle
- dmem_cmd  out  type_scr1_mem_cmd_e  SCR1_MEM_CMD_RD / SCR1_MEM_CMD_WR
- dmem_width  out  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD
- dmem_addr  out  `SCR1_DMEM_AWIDTH  request address
- dmem_wdata  out  `SCR1_DMEM_DWIDTH  write data; word in bits [31:0], upper bits zero
- dmem_rdata  in  `SCR1_DMEM_DWIDTH  read data; word taken from bits [31:0]
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- Transitions:
  - IDLE + start: latch src, dst and len into cur_src, cur_dst and remaining; clear err.
    - len==0: go to FIN.
    - src_addr[1:0] or dst_addr[1:0] nonzero: set err, go to FIN.
    - Otherwise: go to RD_REQ.
  - RD_REQ: dmem_req=1, cmd=RD, addr=cur_src. On dmem_req_ack go to RD_WAIT. Without ack, hold req and all request fields stable.
  - RD_WAIT: dmem_req=0.
    - RDY_OK: capture dmem_rdata[31:0] into data_q, go to WR_REQ.
    - RDY_ER: set err, go to FIN.
    - NOTRDY: stay.
  - WR_REQ: dmem_req=1, cmd=WR, addr=cur_dst, wdata={zeros,data_q}. On ack go to WR_WAIT.
  - WR_WAIT, on RDY_OK:
    - Increment cur_src and cur_dst by 4; arithmetic is modulo 2^AWIDTH, so 0xFFFFFFFC wraps to 0x00000000.
    - Decrement remaining.
    - Go to FIN if remaining becomes 0 or abort_pend is set; otherwise go to RD_REQ.
  - WR_WAIT, on RDY_ER: set err, go to FIN.
  - FIN: done=1 for one cycle, go to IDLE.
- abort:
  - Raising abort in any non-IDLE state sets abort_pend.
  - The engine never drops an asserted req before ack.
  - The engine never abandons an outstanding response.
  - An in-flight read completes together with its write; the word is written, then FIN.
  - abort in IDLE is ignored.
  - abort_pend clears in FIN.
  - An aborted job does not set err.
- start while busy: ignored.
- The block never has more than one accepted, unanswered transaction.

## Timing
- Reset values:
  - Outputs: busy=0, done=0, err=0, dmem_req=0, dmem_cmd=RD, dmem_width=WORD, dmem_addr=0, dmem_wdata=0.
  - State: IDLE; abort_pend=0.
- Reset asserted mid-job: immediate return to IDLE with dmem_req=0. Any response arriving after reset release is ignored in IDLE.
- Cycle-level against the TCM (req_ack tied 1, resp one cycle after accept):
  - Cycle 0: start.
  - Cycle 1: RD_REQ, req high.
  - Cycle 2: RD_WAIT, resp OK.
  - Cycle 3: WR_REQ.
  - Cycle 4: WR_WAIT, resp OK.
  - Cycle 5: next RD_REQ, or FIN.
  - Throughput: 4 cycles per word. N-word job: done in cycle 4N+1, busy high cycles 1..4N+1.
- len==0 or misaligned address: FIN in cycle 1, done in cycle 1, no dmem_req ever asserted.
- busy is high in every non-IDLE state, including FIN.
- All outputs are registered or decoded from state registers; no combinational path from dmem_resp or dmem_req_ack to dmem_req.

## Structure
- Shared package additions:
  - FSM state enum type_scr1_dce_state_e.
  - Constant SCR1_DCE_WORD_STEP = 4.
- The memif types come from the existing memory interface header.
- Single module, no sub-modules. Address/count datapath and FSM are small enough to stay flat.

## Test plan
- len=3, src=0x100, dst=0x200, TCM responder preloaded 0x11111111/0x22222222/0x33333333 -> dst words match; done in cycle 13; exactly 6 accepted requests.
- req_ack held low 5 cycles on the second read -> req, cmd, addr (0x104) stable throughout; copy still correct; done delayed by 5 cycles.
- RDY_ER on the first write of a len=4 job -> no further requests; err=1; done pulse; remaining writes absent.
- src=0xFFFFFFFC, len=2 -> second read address 0x00000000; dst increments normally.
- len=0, and separately src=0x102 -> done in cycle 1; no dmem_req; err=0 and err=1 respectively.
- abort pulsed during RD_WAIT of word 2 of a len=5 job -> word 2 written; no third read; done; err=0. start during busy ignored; reset mid-WR_REQ drops req the same cycle.

Source files
------------

// File: rtl/scr1_dmem_copy_engine_pkg.sv
// scr1_dmem_copy_engine_pkg
//   Shared types for the dmem copy engine: memory-interface widths, command,
//   width and response encodings, the engine FSM state enum and the address
//   step between consecutive words.
package scr1_dmem_copy_engine_pkg;

   localparam int SCR1_DMEM_AWIDTH = 32;
   localparam int SCR1_DMEM_DWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   typedef enum logic [2:0] {
      SCR1_DCE_IDLE    = 3'd0,
      SCR1_DCE_RD_REQ  = 3'd1,
      SCR1_DCE_RD_WAIT = 3'd2,
      SCR1_DCE_WR_REQ  = 3'd3,
      SCR1_DCE_WR_WAIT = 3'd4,
      SCR1_DCE_FIN     = 3'd5
   } type_scr1_dce_state_e;

   localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DCE_WORD_STEP = 4;

endpackage

// File: rtl/scr1_dmem_copy_engine.sv
// scr1_dmem_copy_engine
//   Word-copy master on the SCR1 dmem request/response interface. Copies len
//   32-bit words from src_addr to dst_addr as alternating read/write
//   transactions, one outstanding at a time.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      job launch (IDLE only) / stop at next word boundary
//   src_addr, dst_addr, len   job descriptor, sampled on accepted start
//   busy, done, err   job status: busy while active, done pulse, sticky error
//   dmem_*            request/response interface towards the dmem arbiter
//   dbg_state         current FSM state for observation
//
// Handshake: a request is presented with dmem_req=1 and its cmd/addr/wdata
// held stable until the cycle dmem_req_ack=1 samples it (valid/ready: the
// transfer happens on the rising edge where both are high; req is never
// withdrawn before that). The response is then awaited in a WAIT state until
// dmem_resp is RDY_OK or RDY_ER; NOTRDY means keep waiting.
module scr1_dmem_copy_engine
   import scr1_dmem_copy_engine_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [SCR1_DMEM_AWIDTH-1:0] src_addr,
   input  logic [SCR1_DMEM_AWIDTH-1:0] dst_addr,
   input  logic [CNT_W-1:0]            len,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic                        dmem_req,
   input  logic                        dmem_req_ack,
   output type_scr1_mem_cmd_e          dmem_cmd,
   output type_scr1_mem_width_e        dmem_width,
   output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
   output logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
   input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
   input  type_scr1_mem_resp_e         dmem_resp,
   output type_scr1_dce_state_e        dbg_state
);

   type_scr1_dce_state_e        state, state_nxt;
   logic [SCR1_DMEM_AWIDTH-1:0] cur_src, cur_dst;
   logic [CNT_W-1:0]            remaining;
   logic [31:0]                 data_q;
   logic                        err_q;
   logic                        abort_pend;

   logic job_load;
   logic err_set;
   logic rd_capture;
   logic word_done;

   // Next-state and datapath control
   always_comb begin
      state_nxt  = state;
      job_load   = 1'b0;
      err_set    = 1'b0;
      rd_capture = 1'b0;
      word_done  = 1'b0;
      case (state)
         SCR1_DCE_IDLE: begin
            if (start) begin
               job_load = 1'b1;
               if (len == '0) begin
                  state_nxt = SCR1_DCE_FIN;
               end else if ((|src_addr[1:0]) || (|dst_addr[1:0])) begin
                  err_set   = 1'b1;
                  state_nxt = SCR1_DCE_FIN;
               end else begin
                  state_nxt = SCR1_DCE_RD_REQ;
               end
            end
         end
         SCR1_DCE_RD_REQ: begin
            if (dmem_req_ack) state_nxt = SCR1_DCE_RD_WAIT;
         end
         SCR1_DCE_RD_WAIT: begin
            if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
               rd_capture = 1'b1;
               state_nxt  = SCR1_DCE_WR_REQ;
            end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
               err_set   = 1'b1;
               state_nxt = SCR1_DCE_FIN;
            end
         end
         SCR1_DCE_WR_REQ: begin
            if (dmem_req_ack) state_nxt = SCR1_DCE_WR_WAIT;
         end
         SCR1_DCE_WR_WAIT: begin
            if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
               word_done = 1'b1;
               // remaining is still the pre-decrement value here
               if ((remaining == CNT_W'(1)) || abort_pend) state_nxt = SCR1_DCE_FIN;
               else                                         state_nxt = SCR1_DCE_RD_REQ;
            end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
               err_set   = 1'b1;
               state_nxt = SCR1_DCE_FIN;
            end
         end
         SCR1_DCE_FIN: begin
            state_nxt = SCR1_DCE_IDLE;
         end
         default: begin
            state_nxt = SCR1_DCE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SCR1_DCE_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_src    <= '0;
         cur_dst    <= '0;
         remaining  <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         abort_pend <= 1'b0;
      end else begin
         if (job_load) begin
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= len;
         end
         if (word_done) begin
            // address arithmetic wraps modulo 2^AWIDTH
            cur_src   <= cur_src + SCR1_DCE_WORD_STEP;
            cur_dst   <= cur_dst + SCR1_DCE_WORD_STEP;
            remaining <= remaining - CNT_W'(1);
         end
         if (rd_capture) data_q <= dmem_rdata[31:0];
         // err_set after job_load so a misaligned start leaves err high
         if (job_load) err_q <= 1'b0;
         if (err_set)  err_q <= 1'b1;
         if (state == SCR1_DCE_FIN)                     abort_pend <= 1'b0;
         else if (abort && (state != SCR1_DCE_IDLE))    abort_pend <= 1'b1;
      end
   end

   // All outputs decode from registered state; no path from ack/resp to req
   assign busy       = (state != SCR1_DCE_IDLE);
   assign done       = (state == SCR1_DCE_FIN);
   assign err        = err_q;
   assign dmem_req   = (state == SCR1_DCE_RD_REQ) || (state == SCR1_DCE_WR_REQ);
   assign dmem_width = SCR1_MEM_WIDTH_WORD;
   assign dbg_state  = state;

   always_comb begin
      dmem_cmd   = SCR1_MEM_CMD_RD;
      dmem_addr  = cur_src;
      dmem_wdata = '0;
      dmem_wdata[31:0] = data_q;
      if ((state == SCR1_DCE_WR_REQ) || (state == SCR1_DCE_WR_WAIT)) begin
         dmem_cmd  = SCR1_MEM_CMD_WR;
         dmem_addr = cur_dst;
      end
   end

endmodule

// File: tb/tb_scr1_dmem_copy_engine.sv
module tb_scr1_dmem_copy_engine;
   import scr1_dmem_copy_engine_pkg::*;

   localparam int CNT_W = 16;
   localparam int AW    = SCR1_DMEM_AWIDTH;
   localparam int DW    = SCR1_DMEM_DWIDTH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic [AW-1:0]        src_addr = '0;
   logic [AW-1:0]        dst_addr = '0;
   logic [CNT_W-1:0]     len = '0;
   logic                 busy, done, err;
   logic                 dmem_req;
   logic                 dmem_req_ack = 1'b1;
   type_scr1_mem_cmd_e   dmem_cmd;
   type_scr1_mem_width_e dmem_width;
   logic [AW-1:0]        dmem_addr;
   logic [DW-1:0]        dmem_wdata;
   logic [DW-1:0]        dmem_rdata = '0;
   type_scr1_mem_resp_e  dmem_resp = SCR1_MEM_RESP_NOTRDY;
   type_scr1_dce_state_e dbg_state;

   scr1_dmem_copy_engine #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .err(err),
      .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
      .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [64:0] exp_q[$];   // {is_write, addr, wdata (0 for reads)}

   // responder configuration and observations
   int   cfg_err_idx = -1;
   int   cfg_stall_idx = -1;
   int   stall_left = 0;
   int   cfg_abort_word = 0;
   int   acc_cnt = 0, rd_cnt = 0, busy_cnt = 0, done_cyc = 0, start_cyc = 0;
   bit   done_seen = 0, err_at_done = 0, abort_next = 0;
   bit   pend = 0, pend_wr = 0;
   int   pend_idx = 0;
   logic [31:0] pend_addr = '0, pend_wdata = '0;
   bit   held_valid = 0;
   logic [64:0] held_req = '0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0BAD_0000 ^ a;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 32'h0BAD_0000 ^ a;
   endfunction

   // ---------------- TCM-like responder and monitor (mid-cycle) ----------------
   initial begin
      logic [64:0] req_word;
      logic [64:0] exp_word;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 0; held_valid = 0; abort = 1'b0; abort_next = 0;
            dmem_resp = SCR1_MEM_RESP_NOTRDY; dmem_req_ack = 1'b1;
         end else begin
            abort = abort_next;
            abort_next = 0;
            if (pend) begin
               if (pend_idx == cfg_err_idx) begin
                  dmem_resp = SCR1_MEM_RESP_RDY_ER;
               end else begin
                  dmem_resp = SCR1_MEM_RESP_RDY_OK;
                  if (pend_wr) mem[pend_addr] = pend_wdata;
                  else         dmem_rdata = mem_rd(pend_addr);
               end
               pend = 0;
            end else begin
               dmem_resp = SCR1_MEM_RESP_NOTRDY;
            end
            if (busy) busy_cnt++;
            if (done) begin done_seen = 1; done_cyc = cyc; err_at_done = err; end
            req_word = {dmem_cmd == SCR1_MEM_CMD_WR, dmem_addr,
                        (dmem_cmd == SCR1_MEM_CMD_WR) ? dmem_wdata[31:0] : 32'h0};
            if (held_valid) check("req_stable_while_stalled", {dmem_req, req_word}, {1'b1, held_req});
            if (dmem_req) begin
               check("req_width_word", dmem_width, SCR1_MEM_WIDTH_WORD);
               if (acc_cnt == cfg_stall_idx && stall_left > 0) begin
                  dmem_req_ack = 1'b0;
                  stall_left--;
                  held_valid = 1;
                  held_req = req_word;
               end else begin
                  dmem_req_ack = 1'b1;
                  held_valid = 0;
                  check("req_expected", exp_q.size() > 0, 1);
                  if (exp_q.size() > 0) begin
                     exp_word = exp_q.pop_front();
                     check("req_fields", req_word, exp_word);
                  end
                  pend = 1; pend_idx = acc_cnt;
                  pend_wr = (dmem_cmd == SCR1_MEM_CMD_WR);
                  pend_addr = dmem_addr; pend_wdata = dmem_wdata[31:0];
                  acc_cnt++;
                  if (!pend_wr) begin
                     rd_cnt++;
                     if (rd_cnt == cfg_abort_word) abort_next = 1;
                  end
               end
            end else begin
               dmem_req_ack = 1'b1;
               held_valid = 0;
            end
         end
      end
   end

   // ---------------- reference model: job outcome from the copy rules ----------------
   task automatic model_job(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int e_idx, input int ab_w, input int st_idx, input int st_cyc,
                            output int m_err, output int m_done, output int m_nreq);
      logic [31:0] a_s, a_d, w;
      m_err = 0; m_nreq = 0;
      if (n != 0) begin
         if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
            m_err = 1;
         end else begin
            for (int i = 0; i < n; i++) begin
               a_s = s + 32'(4 * i);
               a_d = d + 32'(4 * i);
               exp_q.push_back({1'b0, a_s, 32'h0});
               m_nreq++;
               if (m_nreq - 1 == e_idx) begin m_err = 1; break; end
               w = ref_rd(a_s);
               exp_q.push_back({1'b1, a_d, w});
               m_nreq++;
               if (m_nreq - 1 == e_idx) begin m_err = 1; break; end
               ref_mem[a_d] = w;
               if (i + 1 == ab_w) break;
            end
         end
      end
      // each accepted transaction costs a request cycle and a response cycle
      m_done = 1 + 2 * m_nreq + ((st_idx >= 0 && st_idx < m_nreq) ? st_cyc : 0);
   endtask

   int m_err, m_done, m_nreq;

   task automatic setup_job(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int e_idx, input int st_idx, input int st_cyc,
                            input int ab_w, input bit rnd);
      for (int i = 0; i < n && i < 8; i++) begin
         mem[s + 32'(4 * i)] = rnd ? $urandom : 32'(32'h1111_1111 * (i + 1));
         mem[d + 32'(4 * i)] = 32'hDEAD_0000 | 32'(i);
      end
      ref_mem = mem;
      exp_q.delete();
      model_job(s, d, n, e_idx, ab_w, st_idx, st_cyc, m_err, m_done, m_nreq);
      cfg_err_idx = e_idx; cfg_stall_idx = st_idx; stall_left = st_cyc;
      cfg_abort_word = ab_w;
      acc_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_seen = 0; held_valid = 0;
   endtask

   // ---------------- driver: run one job and score it ----------------
   task automatic run_job(input string nm, input logic [31:0] s, input logic [31:0] d,
                          input int n, input int e_idx, input int st_idx, input int st_cyc,
                          input int ab_w, input int tab_done, input int tab_err,
                          input int restart_at, input bit rnd);
      int exp_done, exp_err;
      setup_job(s, d, n, e_idx, st_idx, st_cyc, ab_w, rnd);
      exp_done = (tab_done >= 0) ? tab_done : m_done;
      exp_err  = (tab_err  >= 0) ? tab_err  : m_err;
      @(negedge clk);
      src_addr = s; dst_addr = d; len = CNT_W'(n); start = 1'b1; start_cyc = cyc;
      for (int k = 1; k <= 4 * n + st_cyc + 20 && !done_seen; k++) begin
         @(negedge clk);
         if (k == restart_at) begin
            start = 1'b1; src_addr = 32'h0000_C000; dst_addr = 32'h0000_D000; len = 1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
      check({nm, "/done_seen"},   done_seen, 1);
      check({nm, "/done_cycle"},  done_cyc - start_cyc, exp_done);
      check({nm, "/err_at_done"}, err_at_done, exp_err);
      check({nm, "/err_sticky"},  err, exp_err);
      check({nm, "/req_count"},   acc_cnt, m_nreq);
      check({nm, "/req_missing"}, exp_q.size(), 0);
      check({nm, "/busy_cycles"}, busy_cnt, exp_done);
      check({nm, "/idle_after"},  {busy, done, dmem_req}, 3'b000);
      for (int i = 0; i < n && i < 8; i++)
         check({nm, "/dst_word"}, mem_rd(d + 32'(4 * i)), ref_rd(d + 32'(4 * i)));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       nm;
      logic [31:0] s, d;
      int          n, e_idx, st_idx, st_cyc, ab_w, exp_done, exp_err, restart;
   } vec_t;

   vec_t tab[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0] = '{"copy3",        32'h0000_0100, 32'h0000_0200, 3, -1, -1, 0, 0, 13, 0, 0};
      tab[1] = '{"stall_rd2",    32'h0000_0300, 32'h0000_0400, 3, -1,  2, 5, 0, 18, 0, 0};
      tab[2] = '{"wr1_error",    32'h0000_0500, 32'h0000_0600, 4,  1, -1, 0, 0,  5, 1, 0};
      tab[3] = '{"src_wrap",     32'hFFFF_FFFC, 32'h0000_0700, 2, -1, -1, 0, 0,  9, 0, 0};
      tab[4] = '{"len_zero",     32'h0000_0800, 32'h0000_0900, 0, -1, -1, 0, 0,  1, 0, 0};
      tab[5] = '{"src_misalign", 32'h0000_0102, 32'h0000_0A00, 3, -1, -1, 0, 0,  1, 1, 0};
      tab[6] = '{"abort_word2",  32'h0000_0B00, 32'h0000_0C00, 5, -1, -1, 0, 2,  9, 0, 0};
      tab[7] = '{"dst_misalign", 32'h0000_0D00, 32'h0000_0E02, 2, -1, -1, 0, 0,  1, 1, 0};
      tab[8] = '{"start_busy",   32'h0000_1000, 32'h0000_1100, 2, -1, -1, 0, 0,  9, 0, 3};

      // reset values
      repeat (3) @(negedge clk);
      check("rst/busy", busy, 0);
      check("rst/done", done, 0);
      check("rst/err", err, 0);
      check("rst/req", dmem_req, 0);
      check("rst/cmd", dmem_cmd, SCR1_MEM_CMD_RD);
      check("rst/width", dmem_width, SCR1_MEM_WIDTH_WORD);
      check("rst/addr", dmem_addr, 0);
      check("rst/wdata", dmem_wdata, 0);
      check("rst/state", dbg_state, SCR1_DCE_IDLE);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst/idle", {busy, done, dmem_req}, 3'b000);

      for (int i = 0; i < 9; i++)
         run_job(tab[i].nm, tab[i].s, tab[i].d, tab[i].n, tab[i].e_idx, tab[i].st_idx,
                 tab[i].st_cyc, tab[i].ab_w, tab[i].exp_done, tab[i].exp_err, tab[i].restart, 1'b0);

      // reset asserted while a write request is held waiting for ack
      setup_job(32'h0000_2000, 32'h0000_2100, 2, -1, 1, 5, 0, 1'b1);
      @(negedge clk);
      src_addr = 32'h0000_2000; dst_addr = 32'h0000_2100; len = 2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10 && dbg_state != SCR1_DCE_WR_REQ; k++) @(negedge clk);
      check("rst_mid/reached_wr_req", {dbg_state, dmem_req}, {SCR1_DCE_WR_REQ, 1'b1});
      #2 rst = 1'b1;
      #1;
      check("rst_mid/req_dropped", dmem_req, 0);
      check("rst_mid/busy", busy, 0);
      check("rst_mid/state", dbg_state, SCR1_DCE_IDLE);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_mid/no_done", done_seen, 0);
      check("rst_mid/idle", {busy, dmem_req}, 2'b00);
      check("rst_mid/dst_untouched", mem_rd(32'h0000_2100), 32'hDEAD_0000);
      exp_q.delete();
      cfg_stall_idx = -1;

      // abort while idle must not affect the following job
      abort_next = 1;
      repeat (3) @(negedge clk);
      run_job("idle_abort", 32'h0000_3000, 32'h0000_3100, 2, -1, -1, 0, 0, -1, -1, 0, 1'b1);

      // randomized jobs against the model
      for (int j = 0; j < 14; j++) begin
         int n, e_idx, st_idx, st_cyc, ab_w;
         logic [31:0] s, d;
         n      = $urandom_range(1, 6);
         s      = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 4;
         d      = 32'h0002_0000 + 32'($urandom_range(0, 255)) * 4;
         e_idx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
         st_idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
         st_cyc = (st_idx >= 0) ? $urandom_range(1, 4) : 0;
         ab_w   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
         run_job("random", s, d, n, e_idx, st_idx, st_cyc, ab_w, -1, -1, 0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
